// File: rtl/tty_uart_bridge.sv
// tty_uart_bridge: buffers characters written on the core's tty port in a FIFO
// and shifts them out as asynchronous UART frames on a single idle-high pin.
module tty_uart_bridge #(
    parameter int unsigned DATA_W       = 7,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [DATA_W-1:0]      tty_i,
    input  logic                   tty_we_i,
    input  logic                   ovf_clr_i,
    output logic                   tx_o,
    output logic                   busy_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   overflow_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [PTR_W-1:0]    wptr_q, wptr_d;
    logic [PTR_W-1:0]    rptr_q, rptr_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic                ovf_q, ovf_d;
    logic [CNT_W-1:0]    baud_q, baud_d;
    logic [BIT_W-1:0]    bitc_q, bitc_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                par_q, par_d;
    logic                tx_q, tx_d;
    logic                busy_q, busy_d;
    logic                push;
    logic                pop;
    logic                full;
    logic                bit_end;

    // Next-state, FIFO bookkeeping and line level for the following cycle
    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        ovf_d   = ovf_q;
        bitc_d  = bitc_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        push    = 1'b0;
        full    = (level_q == LVL_W'(DEPTH));
        bit_end = (baud_q == CNT_W'(CLKS_PER_BIT - 1));
        baud_d  = bit_end ? '0 : baud_q + CNT_W'(1);

        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                bitc_d = '0;
                tx_d   = 1'b1;
                if (level_q != '0) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rptr_q];
                    par_d   = (^mem_q[rptr_q]) ^ (PARITY == 2);
                    state_d = S_START;
                    tx_d    = 1'b0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    tx_d    = shift_q[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bitc_q == BIT_W'(DATA_W - 1)) begin
                        bitc_d = '0;
                        if (PARITY != 0) begin
                            state_d = S_PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bitc_d  = bitc_q + BIT_W'(1);
                        shift_d = shift_q >> 1;
                        tx_d    = shift_d[0];
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    bitc_d  = '0;
                    tx_d    = 1'b1;
                end
            end
            S_STOP: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    if (bitc_q == BIT_W'(STOP_BITS - 1)) begin
                        state_d = S_IDLE;
                        bitc_d  = '0;
                    end else begin
                        bitc_d = bitc_q + BIT_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // A full FIFO still accepts a write when the head leaves in the same cycle
        push = tty_we_i && (!full || pop);
        if (push) begin
            wptr_d = wptr_q + PTR_W'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + PTR_W'(1);
        end
        level_d = level_q + LVL_W'(push) - LVL_W'(pop);

        if (tty_we_i && full && !pop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr_i) begin
            ovf_d = 1'b0;
        end

        busy_d = (state_q != S_IDLE) || (level_q != '0);
    end

    // State and control registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
            baud_q  <= '0;
            bitc_q  <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
            baud_q  <= baud_d;
            bitc_q  <= bitc_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    // Character storage needs no reset: only entries below level are ever read
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wptr_q] <= tty_i;
        end
    end

    assign tx_o       = tx_q;
    assign busy_o     = busy_q;
    assign level_o    = level_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_tty_uart_bridge.sv
// Bench for tty_uart_bridge: two configurations (7N1 with a 4-deep FIFO, 8O2 with
// an 8-deep FIFO) checked against a frame-level model of the serial line.
module tb_tty_uart_bridge;
    localparam int unsigned CPB     = 4;
    localparam int unsigned A_DW    = 7;
    localparam int unsigned A_DEPTH = 4;
    localparam int unsigned B_DW    = 8;
    localparam int unsigned B_DEPTH = 8;
    localparam int unsigned A_LW    = $clog2(A_DEPTH) + 1;
    localparam int unsigned B_LW    = $clog2(B_DEPTH) + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [A_DW-1:0] a_tty;
    logic            a_we, a_clr, a_tx, a_busy, a_ovf;
    logic [A_LW-1:0] a_level;
    logic [B_DW-1:0] b_tty;
    logic            b_we, b_clr, b_tx, b_busy, b_ovf;
    logic [B_LW-1:0] b_level;

    int tests = 0;
    int fails = 0;

    tty_uart_bridge #(
        .DATA_W(A_DW), .DEPTH(A_DEPTH), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1)
    ) u_dut_a (
        .clk_i(clk), .rst_i(rst), .tty_i(a_tty), .tty_we_i(a_we), .ovf_clr_i(a_clr),
        .tx_o(a_tx), .busy_o(a_busy), .level_o(a_level), .overflow_o(a_ovf)
    );

    tty_uart_bridge #(
        .DATA_W(B_DW), .DEPTH(B_DEPTH), .CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(2)
    ) u_dut_b (
        .clk_i(clk), .rst_i(rst), .tty_i(b_tty), .tty_we_i(b_we), .ovf_clr_i(b_clr),
        .tx_o(b_tx), .busy_o(b_busy), .level_o(b_level), .overflow_o(b_ovf)
    );

    function automatic logic tx_of(input int d);
        return (d != 0) ? b_tx : a_tx;
    endfunction

    function automatic logic busy_of(input int d);
        return (d != 0) ? b_busy : a_busy;
    endfunction

    function automatic logic ovf_of(input int d);
        return (d != 0) ? b_ovf : a_ovf;
    endfunction

    function automatic int level_of(input int d);
        return (d != 0) ? int'(b_level) : int'(a_level);
    endfunction

    function automatic int frame_len(input int d);
        return (d != 0) ? (1 + 8 + 1 + 2) : (1 + 7 + 1);
    endfunction

    // Line level per bit slot: start 0, data LSB first, odd parity (dut B), stop 1s
    function automatic logic [15:0] frame_pat(input int d, input int unsigned c);
        logic [15:0] p;
        int dw;
        int ones;
        dw   = (d != 0) ? 8 : 7;
        ones = 0;
        p    = '1;
        p[0] = 1'b0;
        for (int i = 0; i < dw; i++) begin
            p[1 + i] = c[i];
            ones += int'(c[i]);
        end
        if (d != 0) p[1 + dw] = ((ones % 2) == 0) ? 1'b1 : 1'b0;
        return p;
    endfunction

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_we(input int d, input logic we, input int unsigned c);
        if (d == 0) begin
            a_we  = we;
            a_tty = A_DW'(c);
        end else begin
            b_we  = we;
            b_tty = B_DW'(c);
        end
    endtask

    task automatic set_clr(input int d, input logic v);
        if (d == 0) a_clr = v;
        else        b_clr = v;
    endtask

    // Waits for the start bit (exp_gap idle cycles, or any if negative) then checks every cycle
    task automatic check_frame(input int d, input int unsigned c, input int exp_gap, input int exp_level);
        logic [15:0] p;
        int idle;
        p    = frame_pat(d, c);
        idle = 0;
        @(negedge clk);
        while (tx_of(d) === 1'b1 && idle < 500) begin
            idle++;
            @(negedge clk);
        end
        tests++;
        if (idle >= 500 || (exp_gap >= 0 && idle != exp_gap)) begin
            fails++;
            $display("FAIL start_gap dut%0d char %0h: %0d idle cycles before start, required %0d", d, c, idle, exp_gap);
        end
        tests++;
        if (busy_of(d) !== 1'b1) begin
            fails++;
            $display("FAIL busy_in_frame dut%0d char %0h: busy_o %b, required 1", d, c, busy_of(d));
        end
        if (exp_level >= 0) begin
            tests++;
            if (level_of(d) != exp_level) begin
                fails++;
                $display("FAIL level_at_start dut%0d char %0h: level_o %0d, required %0d", d, c, level_of(d), exp_level);
            end
        end
        for (int b = 0; b < frame_len(d); b++) begin
            for (int k = 0; k < int'(CPB); k++) begin
                if (b != 0 || k != 0) @(negedge clk);
                tests++;
                if (tx_of(d) !== p[b]) begin
                    fails++;
                    $display("FAIL frame_bit dut%0d char %0h slot %0d cycle %0d: tx_o %b, required %b", d, c, b, k, tx_of(d), p[b]);
                end
            end
        end
    endtask

    // After the last stop cycle busy_o stays up one more cycle (registered), then drops
    task automatic check_idle(input int d);
        @(negedge clk);
        tests++;
        if (busy_of(d) !== 1'b1 || tx_of(d) !== 1'b1) begin
            fails++;
            $display("FAIL busy_tail dut%0d: busy_o %b tx_o %b, required 1 1", d, busy_of(d), tx_of(d));
        end
        @(negedge clk);
        tests++;
        if (busy_of(d) !== 1'b0 || tx_of(d) !== 1'b1 || level_of(d) != 0) begin
            fails++;
            $display("FAIL idle_after dut%0d: busy_o %b tx_o %b level_o %0d, required 0 1 0", d, busy_of(d), tx_of(d), level_of(d));
        end
    endtask

    // Writes chars on consecutive cycles into an idle bridge and checks the resulting line
    task automatic run_burst(input int d, input int unsigned chars[$], input bit ovf_ops);
        int unsigned sent[$];
        int lvl[$];
        int depth;
        int occ;
        bit dropped;
        depth   = (d != 0) ? int'(B_DEPTH) : int'(A_DEPTH);
        occ     = 0;
        dropped = 1'b0;
        // The first character leaves the FIFO one cycle after it lands; the rest wait out its frame
        for (int k = 0; k < chars.size(); k++) begin
            if (k == 1) occ--;
            if (occ < depth) begin
                occ++;
                sent.push_back(chars[k]);
            end else begin
                dropped = 1'b1;
            end
            lvl.push_back(occ);
        end
        sync();
        fork
            begin
                for (int k = 0; k < chars.size(); k++) begin
                    drive_we(d, 1'b1, chars[k]);
                    @(posedge clk);
                    @(negedge clk);
                    tests++;
                    if (level_of(d) != lvl[k]) begin
                        fails++;
                        $display("FAIL burst_level dut%0d write %0d: level_o %0d, required %0d", d, k, level_of(d), lvl[k]);
                    end
                end
                drive_we(d, 1'b0, 0);
                tests++;
                if (ovf_of(d) !== dropped) begin
                    fails++;
                    $display("FAIL overflow_flag dut%0d: overflow_o %b, required %b", d, ovf_of(d), dropped);
                end
                if (ovf_ops) begin
                    repeat (3) @(negedge clk);
                    tests++;
                    if (ovf_of(d) !== 1'b1) begin
                        fails++;
                        $display("FAIL overflow_sticky dut%0d: overflow_o %b, required 1", d, ovf_of(d));
                    end
                    set_clr(d, 1'b1);
                    @(posedge clk);
                    @(negedge clk);
                    set_clr(d, 1'b0);
                    tests++;
                    if (ovf_of(d) !== 1'b0) begin
                        fails++;
                        $display("FAIL overflow_clear dut%0d: overflow_o %b, required 0", d, ovf_of(d));
                    end
                    drive_we(d, 1'b1, $urandom & 32'h7F);
                    set_clr(d, 1'b1);
                    @(posedge clk);
                    @(negedge clk);
                    drive_we(d, 1'b0, 0);
                    set_clr(d, 1'b0);
                    tests++;
                    if (ovf_of(d) !== 1'b1 || level_of(d) != depth) begin
                        fails++;
                        $display("FAIL overflow_set_wins dut%0d: overflow_o %b level_o %0d, required 1 %0d", d, ovf_of(d), level_of(d), depth);
                    end
                    set_clr(d, 1'b1);
                    @(posedge clk);
                    @(negedge clk);
                    set_clr(d, 1'b0);
                    tests++;
                    if (ovf_of(d) !== 1'b0) begin
                        fails++;
                        $display("FAIL overflow_reclear dut%0d: overflow_o %b, required 0", d, ovf_of(d));
                    end
                end
            end
            begin
                for (int j = 0; j < sent.size(); j++) begin
                    check_frame(d, sent[j], (j == 0) ? 2 : 1, (j == 0) ? -1 : (sent.size() - 1 - j));
                end
            end
        join
        check_idle(d);
    endtask

    task automatic check_quiet(input string tag);
        tests++;
        if (a_tx !== 1'b1 || a_busy !== 1'b0 || a_level !== '0 || a_ovf !== 1'b0) begin
            fails++;
            $display("FAIL %s dut0: tx %b busy %b level %0d ovf %b, required 1 0 0 0", tag, a_tx, a_busy, a_level, a_ovf);
        end
        tests++;
        if (b_tx !== 1'b1 || b_busy !== 1'b0 || b_level !== '0 || b_ovf !== 1'b0) begin
            fails++;
            $display("FAIL %s dut1: tx %b busy %b level %0d ovf %b, required 1 0 0 0", tag, b_tx, b_busy, b_level, b_ovf);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_quiet("reset_held");
        sync();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_quiet("idle_after_reset");
        end
    endtask

    task automatic test_single_char();
        int unsigned q[$];
        q.push_back(32'h48);
        run_burst(0, q, 1'b0);
    endtask

    task automatic test_parity_stop();
        int unsigned q[$];
        q.push_back(32'hA5);
        run_burst(1, q, 1'b0);
    endtask

    task automatic test_back_to_back();
        int unsigned qa[$];
        int unsigned qb[$];
        for (int i = 0; i < 5; i++) qa.push_back($urandom & 32'h7F);
        run_burst(0, qa, 1'b0);
        for (int i = 0; i < 4; i++) qb.push_back($urandom & 32'hFF);
        run_burst(1, qb, 1'b0);
    endtask

    task automatic test_overflow();
        int unsigned q[$];
        for (int i = 0; i < 7; i++) q.push_back($urandom & 32'h7F);
        run_burst(0, q, 1'b1);
    endtask

    task automatic test_reset_mid_frame();
        int unsigned c0;
        int unsigned q[$];
        c0 = $urandom & 32'h7F;
        sync();
        for (int k = 0; k < 3; k++) begin
            drive_we(0, 1'b1, (k == 0) ? c0 : ($urandom & 32'h7F));
            @(posedge clk);
            @(negedge clk);
        end
        drive_we(0, 1'b0, 0);
        // Start bit began two edges after the first write; land inside data bit 3
        repeat (16) @(posedge clk);
        #2;
        tests++;
        if (a_tx !== c0[3]) begin
            fails++;
            $display("FAIL pre_abort_bit3 dut0: tx_o %b, required %b", a_tx, c0[3]);
        end
        rst = 1'b1;
        #1;
        tests++;
        if (a_tx !== 1'b1 || a_level !== '0 || a_busy !== 1'b0) begin
            fails++;
            $display("FAIL abort_reset dut0: tx %b level %0d busy %b, required 1 0 0", a_tx, a_level, a_busy);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_quiet("after_abort");
        q.push_back($urandom & 32'h7F);
        run_burst(0, q, 1'b0);
    endtask

    initial begin
        rst   = 1'b1;
        a_tty = '0;
        a_we  = 1'b0;
        a_clr = 1'b0;
        b_tty = '0;
        b_we  = 1'b0;
        b_clr = 1'b0;
        test_reset();
        test_single_char();
        test_parity_stop();
        test_back_to_back();
        test_overflow();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run, %0d failed", tests, fails);
        $fatal(1, "time limit");
    end

endmodule
